// File: rtl/op_loop_sequencer_pkg.sv
// Shared types and default sizes for the op loop sequencer.
// Entry kinds arriving from decode, sequencer FSM states, queue geometry.
// Default op width comes from OP_SIZE when the build does not define it.
`ifndef OP_SIZE
`define OP_SIZE 32
`endif

package op_loop_sequencer_pkg;

  localparam int OP_W_DEF   = `OP_SIZE;
  localparam int DEPTH_DEF  = 64;
  localparam int ADDR_W_DEF = 6;
  localparam int CNT_W_DEF  = 8;

  // Upstream entry kind; 3 is reserved and flagged as a protocol error.
  typedef enum logic [1:0] {
    KIND_OP         = 2'd0,
    KIND_LOOP_BEGIN = 2'd1,
    KIND_LOOP_END   = 2'd2,
    KIND_RSVD       = 2'd3
  } kind_e;

  // STREAM: plain pass-through; BODY: first pass of a loop body is being
  // captured; REWIND: one-cycle read pointer restore; REPLAY: body re-issue.
  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_BODY   = 2'd1,
    ST_REWIND = 2'd2,
    ST_REPLAY = 2'd3
  } state_e;

endpackage

// File: rtl/op_loop_sequencer_if.sv
// Bundle of the sequencer's upstream, queue-control and executor signals.
// master: the sequencer side; slave: decode, queue and executor side.
// Queue head (q_data_out) is combinational from the queue storage.
interface op_loop_sequencer_if
  import op_loop_sequencer_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_kind;
  logic [OP_W-1:0] in_op;

  logic            q_push;
  logic            q_pop;
  logic            q_next;
  logic            q_reset;
  logic [OP_W-1:0] q_data_in;
  logic [OP_W-1:0] q_data_out;

  logic            ex_valid;
  logic            ex_ready;
  logic [OP_W-1:0] ex_op;

  logic            busy;
  logic            err;

  modport master (
    input  in_valid, in_kind, in_op, q_data_out, ex_ready,
    output in_ready, q_push, q_pop, q_next, q_reset, q_data_in,
           ex_valid, ex_op, busy, err
  );

  modport slave (
    output in_valid, in_kind, in_op, q_data_out, ex_ready,
    input  in_ready, q_push, q_pop, q_next, q_reset, q_data_in,
           ex_valid, ex_op, busy, err
  );

endinterface

// File: rtl/op_loop_sequencer.sv
// Op queue controller: pushes decoded ops, pops them to the executor, and
// replays a captured loop body N times via queue checkpoint/rewind.
// Accepted op reaches the executor one cycle later; one bubble per rewind.
module op_loop_sequencer
  import op_loop_sequencer_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  op_loop_sequencer_if.master bus
);

  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  ONE_A   = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e           state_q;
  logic [ADDR_W:0]  occ_q, occ_d;
  logic [ADDR_W:0]  body_len_q;
  logic [CNT_W-1:0] iter_q;
  logic             err_q;
  logic             busy_q;
  logic             q_reset_q;

  kind_e            kind;
  logic [CNT_W-1:0] loop_n;
  logic             occ_empty, occ_room, body_room;
  logic             in_rdy, accept, push, pop, ex_vld, overflow;

  assign kind      = kind_e'(bus.in_kind);
  assign loop_n    = bus.in_op[CNT_W-1:0];
  assign occ_empty = (occ_q == '0);
  assign occ_room  = (occ_q < DEPTH_C);
  assign body_room = (body_len_q < DEPTH_C);

  // Upstream ready per state and entry kind; loop commands wait for a drained queue.
  always_comb begin
    in_rdy = 1'b0;
    case (state_q)
      ST_STREAM: begin
        case (kind)
          KIND_OP:         in_rdy = occ_room;
          KIND_LOOP_BEGIN: in_rdy = occ_empty;
          default:         in_rdy = 1'b1;
        endcase
      end
      ST_BODY: begin
        case (kind)
          KIND_OP:       in_rdy = occ_room & body_room;
          KIND_LOOP_END: in_rdy = occ_empty;
          default:       in_rdy = 1'b1;
        endcase
      end
      default: in_rdy = 1'b0;
    endcase
  end

  assign accept   = bus.in_valid & in_rdy;
  assign push     = accept & (kind == KIND_OP);
  // REWIND is the only state that hides the queue head from the executor.
  assign ex_vld   = (state_q != ST_REWIND) & ~occ_empty;
  assign pop      = ex_vld & bus.ex_ready;
  // A body that no longer fits in the queue cannot be replayed.
  assign overflow = bus.in_valid & (state_q == ST_BODY) & (kind == KIND_OP) &
                    (body_len_q == DEPTH_C);

  // Occupancy tracks push/pop, and snaps to the body length when rewinding.
  always_comb begin
    occ_d = occ_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    if (q_reset_q) occ_d = body_len_q;
  end

  // Sequencer FSM with its counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STREAM;
      occ_q      <= '0;
      body_len_q <= '0;
      iter_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      q_reset_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      case (state_q)
        ST_STREAM: begin
          if (accept) begin
            case (kind)
              KIND_LOOP_BEGIN: begin
                body_len_q <= '0;
                state_q    <= ST_BODY;
                busy_q     <= 1'b1;
              end
              KIND_LOOP_END, KIND_RSVD: err_q <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_BODY: begin
          if (overflow) begin
            // Abandon the loop: the captured ops simply run once.
            err_q   <= 1'b1;
            state_q <= ST_STREAM;
            busy_q  <= 1'b0;
          end else if (accept) begin
            case (kind)
              KIND_OP: body_len_q <= body_len_q + ONE_A;
              KIND_LOOP_END: begin
                if ((loop_n <= ONE_C) || (body_len_q == '0)) begin
                  state_q <= ST_STREAM;
                  busy_q  <= 1'b0;
                end else begin
                  iter_q    <= loop_n - ONE_C;
                  state_q   <= ST_REWIND;
                  q_reset_q <= 1'b1;
                end
              end
              default: err_q <= 1'b1;  // nested LOOP_BEGIN or reserved kind
            endcase
          end
        end
        ST_REWIND: begin
          state_q   <= ST_REPLAY;
          q_reset_q <= 1'b0;
        end
        ST_REPLAY: begin
          if (pop && (occ_q == ONE_A)) begin
            if (iter_q == ONE_C) begin
              iter_q  <= '0;
              state_q <= ST_STREAM;
              busy_q  <= 1'b0;
            end else begin
              iter_q    <= iter_q - ONE_C;
              state_q   <= ST_REWIND;
              q_reset_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_STREAM;
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.q_push    = push;
  assign bus.q_pop     = pop;
  assign bus.q_next    = accept & (kind == KIND_LOOP_BEGIN) & (state_q == ST_STREAM);
  assign bus.q_reset   = q_reset_q;
  assign bus.q_data_in = bus.in_op[OP_W-1:0];
  assign bus.ex_valid  = ex_vld;
  assign bus.ex_op     = bus.q_data_out[OP_W-1:0];
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: doc/op_loop_sequencer.md
Name: op_loop_sequencer

Overview:
- Controller for the op storage queue: accepts an incoming op stream, pushes ops into the queue and pops them to the executor over a valid/ready handshake.
- Implements single-level hardware loops by driving the queue's checkpoint (q_next) and rewind (q_reset) controls, so a loop body is fetched once and replayed N times.
- Sits between the op fetch/decode stage and the executor, beside the storage queue instance.

Parameters:
- OP_W, `OP_SIZE: op word width.
- DEPTH, 64: queue depth in entries.
- ADDR_W, 6: queue address width, log2(DEPTH).
- CNT_W, 8: loop iteration count width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  upstream entry accepted when in_valid & in_ready.
- in_kind  in  2  entry kind: 0 OP, 1 LOOP_BEGIN, 2 LOOP_END, 3 reserved.
- in_op  in  OP_W  op word; for LOOP_END, bits [CNT_W-1:0] hold total iteration count N.
- q_push  out  1  queue push.
- q_pop  out  1  queue pop.
- q_next  out  1  queue checkpoint: capture the read pointer.
- q_reset  out  1  queue rewind: read pointer := checkpoint.
- q_data_in  out  OP_W  queue write data, equal to in_op.
- q_data_out  in  OP_W  queue head, combinational from the queue.
- ex_valid  out  1  op available to the executor.
- ex_ready  in  1  executor accepts.
- ex_op  out  OP_W  op to the executor, equal to q_data_out.
- busy  out  1  state != STREAM.
- err  out  1  sticky protocol/overflow error.

Behaviour:
- Reset: state=STREAM, occ=0, body_len=0, iter=0, err=0. All outputs 0 except in_ready, which follows the rule below (1 for OP while occ<DEPTH). The queue shares rst.
- occ is an internal ADDR_W+1-bit counter. Each cycle: occ += q_push - q_pop, except on a q_reset edge, where occ := body_len.
- ex_valid = (state in STREAM, BODY, REPLAY) & occ != 0.
- q_pop = ex_valid & ex_ready.
- Latency: an OP accepted at edge t is presented on ex_op after edge t+1.
- OP kind:
  - in_ready = occ < DEPTH in STREAM; occ < DEPTH & body_len < DEPTH in BODY; 0 in REWIND and REPLAY.
  - Acceptance: q_push=1.
  - In BODY, body_len++.
  - Push and pop in the same cycle are allowed.
- LOOP_BEGIN, STREAM:
  - in_ready = occ == 0, so the command stalls until the queue drains.
  - Acceptance: q_next=1 for one cycle, body_len:=0, state:=BODY. Nothing is pushed.
- LOOP_BEGIN, BODY (nesting): accepted immediately, err:=1, dropped, state unchanged.
- LOOP_END, BODY:
  - in_ready = occ == 0, i.e. the first pass has fully executed.
  - On acceptance with N<=1 or body_len==0: state:=STREAM.
  - Otherwise: iter:=N-1, state:=REWIND.
- LOOP_END, STREAM: accepted, err:=1, dropped.
- Reserved kind: accepted, err:=1, dropped.
- Body overflow: OP in BODY with body_len==DEPTH cannot be accepted.
  - Instead, on that valid cycle: err:=1, state:=STREAM (loop abandoned, body runs once).
  - The OP is then accepted under STREAM rules.
- REWIND (one cycle): q_reset=1, q_pop=0, ex_valid=0; occ:=body_len; state:=REPLAY.
- REPLAY:
  - Pop on handshake.
  - When the pop with occ==1 occurs: if iter==1, state:=STREAM, iter:=0; else iter--, state:=REWIND.
- Mutual exclusion: q_reset is never asserted with q_pop or q_push. q_next is never asserted with q_pop.
- Loop accounting: total body executions = max(N,1). Executor throughput is 1 op/cycle except for one bubble per rewind.
- rst mid-operation: immediate return to the reset state; any loop in progress is discarded.

Decomposition:
- Shared package: entry-kind enum (OP, LOOP_BEGIN, LOOP_END), sequencer state enum (STREAM, BODY, REWIND, REPLAY), and default constants for DEPTH, ADDR_W, CNT_W.
- No sub-module: occ, body_len and iter counters plus the FSM stay in one module.
- The bench instantiates this block with the storage queue.

Test Plan:
- Stream ops A,B,C with ex_ready=1 -> ex_op A,B,C on consecutive cycles, first one cycle after acceptance; occ returns to 0; err=0.
- LOOP_BEGIN; ops 1,2,3; LOOP_END N=3 -> executor sees 1,2,3,1,2,3,1,2,3 with exactly one bubble before each replay; busy falls after the last pop; in_ready=0 during replays.
- LOOP_BEGIN arrives with occ=2 and ex_ready low -> in_ready=0 until both ops pop; q_next pulses exactly once, afterwards.
- LOOP_END N=1, N=0, and empty body -> no q_reset; state returns to STREAM; body executed once.
- Body of 65 ops with DEPTH=64 -> err=1 on the 65th; loop abandoned; all 65 ops executed once in order.
- Assert rst during REPLAY iteration 2 of 4 -> next cycle ex_valid=0, occ=0, busy=0, err=0, in_ready=1.
